// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: phase encoding, rank count and rank-to-phase mapping for the FFT pipeline sequencer
package fft_ctrl_pkg;
  typedef enum logic [1:0] {PH1, GAP1, PH2, GAP2} phase_t;
  localparam int NUM_RANKS = 4;
  function automatic phase_t rank_phase(input int k);
    return k[0] ? PH2 : PH1;
  endfunction
endpackage

// File: rtl/fft_phase_gen.sv
// fft_phase_gen: beat phase register (clk, rst -> phase); PH1/GAP1/PH2/GAP2 with FFT_CTRL_GAP_EN, else PH1/PH2
module fft_phase_gen import fft_ctrl_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] phase
);
  phase_t ph;
  assign phase = ph;
`ifdef FFT_CTRL_GAP_EN
  always_ff @(posedge clk) ph <= rst ? PH1 : phase_t'(ph + 2'd1);
`else
  always_ff @(posedge clk) ph <= (rst || ph != PH1) ? PH1 : PH2;
`endif
endmodule

// File: rtl/fft_pipe_ctrl.sv
// fft_pipe_ctrl: rank enables, frame valid/ready handshakes, flush and completed-frame count for the 8-point FFT pipe (beat gaps with FFT_CTRL_GAP_EN)
module fft_pipe_ctrl import fft_ctrl_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [NUM_RANKS-1:0] rank_en,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt
);
  logic [1:0] phase;
  logic [NUM_RANKS-1:0] full;
  logic [NUM_RANKS-1:0] src;
  logic open_ok;
  logic take;
  fft_phase_gen u_phase (
    .clk   (clk),
    .rst   (rst),
    .phase (phase)
  );
  assign open_ok = !rst && !flush;
  assign src = {full[NUM_RANKS-2:0], in_valid};
  assign in_ready = open_ok && phase == rank_phase(0) && !full[0];
  assign out_valid = full[NUM_RANKS-1];
  assign take = out_valid && out_ready && !flush;
  assign busy = |full;
  always_comb begin
    rank_en = '0;
    for (int k = 0; k < NUM_RANKS; k++)
      rank_en[k] = open_ok && phase == rank_phase(k) && src[k] && !full[k];
  end
  always_ff @(posedge clk) begin
    full <= (rst || flush) ? '0 : (full | rank_en) & ~{take, rank_en[NUM_RANKS-1:1]};
    frame_cnt <= rst ? '0 : frame_cnt + CNT_W'(take);
  end
endmodule

// File: doc/fft_pipe_ctrl.md
# fft_pipe_ctrl

Sequencer for the 8-point radix-2 pipelined FFT datapath. It replaces the free-running two-phase latch clocks with per-rank latch enables derived from one system clock. It tracks which of the four latch ranks (input, 8→4, 4→2, DFT2/output) hold a live frame, and exposes valid/ready handshakes on the frame input and output. It sits beside the datapath: it drives the rank enables and owns the frame-level flow control.

## Interface
Parameters:
- `CNT_W`, 16, width of the completed-frame counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  an 8-sample frame is present on the datapath inputs.
- `in_ready`  out  1  the frame is captured into rank 0 this cycle when `in_valid` is also high.
- `out_valid`  out  1  rank 3 holds a finished frame.
- `out_ready`  in  1  downstream consumes the frame.
- `flush`  in  1  synchronous discard of all in-flight frames.
- `rank_en`  out  4  latch enable per rank; bit k high = rank k transparent this cycle.
- `busy`  out  1  any rank full.
- `frame_cnt`  out  CNT_W  count of frames handed off at the output; wraps at 2^CNT_W.

## Operation
- Phase generator cycles PH1 → GAP1 → PH2 → GAP2 → PH1. One pass is a beat of 4 cycles.
- Even ranks (0, 2) may open only in PH1; odd ranks (1, 3) only in PH2. Even and odd ranks are never enabled in the same cycle.
- `full[3:0]` is a register, one bit per rank.
- `rank_en[0] = PH1 & in_valid & !full[0]`.
- `in_ready = PH1 & !full[0]`.
- `rank_en[k]` for k = 1..3 is asserted when the rank's phase is active, `full[k-1]` is set and `full[k]` is clear.
- A cycle with `rank_en[k]` high sets `full[k]` and clears `full[k-1]` (k ≥ 1) at the next edge.
- `out_valid = full[3]`. When `out_valid & out_ready`, `full[3]` clears and `frame_cnt` increments.
- Backpressure: if `full[3]` is held, rank 3 stays closed and upstream ranks fill and then hold. No data is overwritten and no frame is dropped.
- `flush`: clears `full` and forces `rank_en = 0` and `in_ready = 0` that cycle. The phase register is unaffected and `frame_cnt` is kept. Flush has priority over every handshake in the same cycle.
- `busy = |full`.

## Timing
- Reset values:
  - `rank_en = 0`, `in_ready = 0`, `out_valid = 0`, `busy = 0`, `frame_cnt = 0`, `full = 0`.
  - Phase is PH1 in the first cycle after `rst` is released.
- Reset mid-operation discards all frames. There is no partial output.
- Latency, with the frame accepted in cycle t (PH1):
  - `rank_en[1]` at t+2, `rank_en[2]` at t+4, `rank_en[3]` at t+6.
  - `out_valid` rises at t+7.
- Throughput: one frame per beat (every 4 cycles) with `out_ready` held high.
- `out_valid` stays high and the datapath outputs stay stable until the handshake.
- A rank 3 consumed at edge e may reopen in the next PH2 after e.
- `frame_cnt` wraps from all-ones to 0 with no flag.

## Configuration
- `FFT_CTRL_GAP_EN` defined: the 4-state beat with non-overlap gap cycles, as above. Latency is 7 and throughput is 1 frame per 4 cycles.
- Not defined: the phase generator alternates PH1 ↔ PH2 with no gaps. Latency is 4 (`rank_en[1..3]` at t+1, t+2, t+3; `out_valid` at t+4), and throughput is 1 frame per 2 cycles.
- All other rules are unchanged in both builds.

## Structure
- Package `fft_ctrl_pkg`:
  - phase enum `{PH1, GAP1, PH2, GAP2}`
  - `NUM_RANKS = 4`
  - function mapping a rank index to its phase (even→PH1, odd→PH2)
- Sub-module `fft_phase_gen`: phase register and next-phase logic, with the gap states compiled per `FFT_CTRL_GAP_EN`. Inputs are `clk`/`rst`; output is the current phase.
- `fft_pipe_ctrl` holds the `full` bits, the enable and handshake decode, and `frame_cnt`.

## Test plan
- Single frame, gap build: hold `in_valid` from cycle 0 after reset.
  - Accepted at t=0; `rank_en` pulses 0001@0, 0010@2, 0100@4, 1000@6.
  - `out_valid` at 7; with `out_ready = 1`, `frame_cnt = 1` at cycle 8.
- Streaming: 8 back-to-back frames with `out_ready = 1` → one acceptance every 4 cycles; `frame_cnt = 8` after the last handshake; `in_ready` never low during PH1.
- Backpressure: `out_ready = 0` for 40 cycles while feeding frames.
  - `full` reaches 1111 and `in_ready = 0` until release.
  - Release drains all 4 frames in order, with `frame_cnt` increasing by 4.
- Flush mid-flight: with `full = 0110`, pulse `flush` → `full = 0000`, `out_valid` never rises, `frame_cnt` unchanged; the next frame completes normally.
- Reset mid-flight: assert `rst` with `full = 1010` and `out_ready = 0` → all outputs at reset values on the next edge; phase is PH1 on the first cycle after release.
- No-gap build: same as the single-frame test → `rank_en` at 0/1/2/3, `out_valid` at 4; streaming accepts every 2 cycles.
